imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Streams a program image into instruction memory over a byte-wide valid/ready link and holds
//  the CPU in reset until a complete, checksum-verified image has been written.
//  It is the writer side of the IF-stage instruction ROM, replacing $readmemh in FPGA builds.
//  It sits between a UART/host byte source and the imem write port; its cpu_rst output gates
//  the core reset.
// PARAMETERS
//  ADDR_WIDTH  10  word-address width of imem; capacity MAX_WORDS = 2**ADDR_WIDTH
// PORTS
//  clk           in   1           system clock, all logic on rising edge
//  rst           in   1           synchronous, active-high reset
//  in_valid      in   1           byte source has data
//  in_data       in   8           byte from source
//  in_ready      out  1           loader accepts byte; transfer = in_valid & in_ready
//  imem_we       out  1           one-cycle imem write strobe
//  imem_addr     out  ADDR_WIDTH  word address of write
//  imem_wdata    out  32          instruction word
//  cpu_rst       out  1           hold core in reset; 0 only after a good load
//  done          out  1           image loaded and verified (sticky until rst)
//  error         out  1           frame error; cleared when a new 0xA5 is accepted
//  loaded_words  out  ADDR_WIDTH+1  words written in current frame
// BEHAVIOUR
//  Frame: 0xA5, LEN_LO, LEN_HI (N words), 4*N payload bytes (each word little-endian), CSUM.
//  CSUM = XOR of all payload bytes only. It excludes the magic and length bytes; 0x00 when N=0.
//  FSM states: IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR. Each state advances on one accepted byte.
//   IDLE: 0xA5 -> LEN0; any other byte is dropped.
//   LEN0 -> LEN1.
//   LEN1: N > MAX_WORDS -> ERR; N == 0 -> CSUM; otherwise -> DATA.
//   DATA: assembles bytes into a word. On acceptance of the 4th byte, imem_we=1 in the NEXT cycle
//    with the current addr/wdata, then addr increments. After word N -> CSUM.
//   CSUM: match -> DONE; mismatch -> ERR.
//   DONE: in_ready=0, done=1, cpu_rst=0. Stays here until rst.
//   ERR: in_ready=1, error=1, cpu_rst=1. An accepted 0xA5 clears error, zeroes addr, count and
//    checksum, and -> LEN0. Other bytes are dropped.
//  in_ready=1 in every state except DONE. in_ready is combinational from state only and never
//   from in_valid.
//  done and cpu_rst change in the cycle after the CSUM byte is accepted.
//  imem_we is never asserted outside DATA-derived writes; at most one write per 4 accepted bytes.
//  Gaps in in_valid have no effect on results; partial-word byte position is held across gaps.
//  Words written before an ERR remain in imem, and cpu_rst still stays 1.
//  Reset values: state=IDLE, in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1,
//   done=0, error=0, loaded_words=0.
//  rst mid-frame: returns to IDLE next cycle; partial word discarded; no write strobe issued.
//  Address never wraps: N is range-checked at LEN1, so addr <= MAX_WORDS-1.
// TESTING
//  1 Good load: send A5 02 00 13 00 10 00 93 00 20 00 B0.
//    -> we@addr0=0x00100013, we@addr1=0x00200093, loaded_words=2, then done=1, cpu_rst=0.
//  2 Bad checksum: same frame with CSUM=B1 -> error=1, done=0, cpu_rst=1.
//    Then resend test 1 frame -> error clears on A5, done=1.
//  3 Leading garbage: 00 FF 5A before test 1 frame -> dropped; writes identical to test 1.
//  4 Backpressure and gaps: test 1 frame with in_valid deasserted every other cycle
//    -> same two writes, same data and addresses, exactly 2 imem_we pulses.
//  5 Boundaries (ADDR_WIDTH=4):
//    A5 11 00 -> error right after LEN_HI, no imem_we.
//    A5 00 00 00 -> done=1, no imem_we.
//  6 Reset mid-DATA: assert rst after 6 bytes of test 1 frame -> IDLE, addr=0, cpu_rst=1, no write.
//    Then full test 1 frame -> done=1.
//  7 Post-done: after test 1, drive in_valid=1 with A5 -> in_ready=0, state/outputs unchanged.

Source files
------------

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_if
//  Description : Byte-stream input, imem write port and load-status bundle
//                for the instruction-memory loader.
//  Revision    : 1.0  initial release
// ============================================================================
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;
    logic                  cpu_rst;
    logic                  done;
    logic                  error;
    logic [ADDR_WIDTH:0]   loaded_words;

    // Loader side: consumes bytes, drives imem and status
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata,
        output cpu_rst,
        output done,
        output error,
        output loaded_words
    );

    // Host side: produces bytes, observes imem and status
    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata,
        input  cpu_rst,
        input  done,
        input  error,
        input  loaded_words
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Receives a framed, XOR-checksummed program image over a
//                byte valid/ready link, writes it into imem one word at a
//                time and releases the CPU reset only after a verified load.
//  Revision    : 1.0  initial release
// ============================================================================
module imem_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  wire logic    clk,
    input  wire logic    rst,
    imem_loader_if.slave bus
);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_LEN0 = 3'd1;
    localparam logic [2:0] c_ST_LEN1 = 3'd2;
    localparam logic [2:0] c_ST_DATA = 3'd3;
    localparam logic [2:0] c_ST_CSUM = 3'd4;
    localparam logic [2:0] c_ST_DONE = 3'd5;
    localparam logic [2:0] c_ST_ERR  = 3'd6;

    localparam logic [7:0]  c_MAGIC     = 8'hA5;
    localparam int unsigned c_MAX_WORDS = 2 ** ADDR_WIDTH;

    logic [2:0]            r_state;
    logic [7:0]            r_len_lo;
    logic [15:0]           r_len;
    logic [1:0]            r_pos;
    logic [23:0]           r_word;
    logic [7:0]            r_csum;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_we;
    logic [31:0]           r_wdata;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_is_magic;
    logic [15:0]           w_len_in;
    logic [ADDR_WIDTH:0]   w_count_inc;
    logic                  w_last_word;

    // Ready depends on state only, so the source never sees a combinational
    // path from its own valid back to ready.
    assign w_ready     = (r_state != c_ST_DONE);
    assign w_accept    = bus.in_valid & w_ready;
    assign w_is_magic  = (bus.in_data == c_MAGIC);
    assign w_len_in    = {bus.in_data, r_len_lo};
    assign w_count_inc = r_count + (ADDR_WIDTH + 1)'(1);
    assign w_last_word = (32'(w_count_inc) == 32'(r_len));

    // Frame parser, word assembler, checksum and imem write generation
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_len_lo <= '0;
            r_len    <= '0;
            r_pos    <= '0;
            r_word   <= '0;
            r_csum   <= '0;
            r_addr   <= '0;
            r_count  <= '0;
            r_we     <= 1'b0;
            r_wdata  <= '0;
        end else begin
            r_we <= 1'b0;
            // Advance the address after each write except the final one, so
            // the address stays within MAX_WORDS-1 even for a full image.
            if (r_we && (r_state == c_ST_DATA)) begin
                r_addr <= r_addr + ADDR_WIDTH'(1);
            end
            if (w_accept) begin
                case (r_state)
                    c_ST_IDLE, c_ST_ERR: begin
                        if (w_is_magic) begin
                            r_state <= c_ST_LEN0;
                            r_addr  <= '0;
                            r_count <= '0;
                            r_csum  <= '0;
                            r_pos   <= '0;
                        end
                    end
                    c_ST_LEN0: begin
                        r_len_lo <= bus.in_data;
                        r_state  <= c_ST_LEN1;
                    end
                    c_ST_LEN1: begin
                        r_len <= w_len_in;
                        if (32'(w_len_in) > c_MAX_WORDS) begin
                            r_state <= c_ST_ERR;
                        end else if (w_len_in == 16'd0) begin
                            r_state <= c_ST_CSUM;
                        end else begin
                            r_state <= c_ST_DATA;
                        end
                    end
                    c_ST_DATA: begin
                        r_csum <= r_csum ^ bus.in_data;
                        if (r_pos == 2'd3) begin
                            // Little-endian: the fourth byte is the MSB
                            r_we    <= 1'b1;
                            r_wdata <= {bus.in_data, r_word};
                            r_count <= w_count_inc;
                            r_pos   <= 2'd0;
                            if (w_last_word) begin
                                r_state <= c_ST_CSUM;
                            end
                        end else begin
                            r_word[{r_pos, 3'b000} +: 8] <= bus.in_data;
                            r_pos <= r_pos + 2'd1;
                        end
                    end
                    c_ST_CSUM: begin
                        r_state <= (bus.in_data == r_csum) ? c_ST_DONE : c_ST_ERR;
                    end
                    c_ST_DONE: begin
                        r_state <= c_ST_DONE;
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.in_ready     = w_ready;
    assign bus.imem_we      = r_we;
    assign bus.imem_addr    = r_addr;
    assign bus.imem_wdata   = r_wdata;
    assign bus.cpu_rst      = (r_state != c_ST_DONE);
    assign bus.done         = (r_state == c_ST_DONE);
    assign bus.error        = (r_state == c_ST_ERR);
    assign bus.loaded_words = r_count;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Directed scoreboard bench for imem_loader. Expected imem
//                writes are queued as frames are issued; a negedge monitor
//                pops and compares each write strobe.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imem_loader;

    localparam int AW = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    wr_t  exp_q[$];
    wr_t  mon_w;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [7:0] good_frame [12] = '{8'hA5, 8'h02, 8'h00,
                                    8'h13, 8'h00, 8'h10, 8'h00,
                                    8'h93, 8'h00, 8'h20, 8'h00,
                                    8'hB0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the oldest queued write
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                         bus.imem_addr, bus.imem_wdata);
            end else begin
                mon_w = exp_q.pop_front();
                chk("write_addr", 32'(bus.imem_addr), 32'(mon_w.addr));
                chk("write_data", bus.imem_wdata, mon_w.data);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit acc;
        int t;
        acc = 1'b0;
        t   = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!acc && t < 50) begin
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        bus.in_valid = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: byte 0x%0h not accepted in 50 cycles, expected acceptance", b);
        end
        if (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_good();
        exp_q.push_back({AW'(0), 32'h0010_0013});
        exp_q.push_back({AW'(1), 32'h0020_0093});
    endtask

    task automatic send_good(input bit gap, input bit bad_csum);
        logic [7:0] b;
        for (int i = 0; i < 12; i++) begin
            b = good_frame[i];
            if (bad_csum && i == 11) b = 8'hB1;
            send_byte(b, gap);
        end
    endtask

    task automatic check_status(input string tag, input logic d, input logic e,
                                input logic cr, input int lw);
        chk({tag, "_done"},    32'(bus.done),         32'(d));
        chk({tag, "_error"},   32'(bus.error),        32'(e));
        chk({tag, "_cpu_rst"}, 32'(bus.cpu_rst),      32'(cr));
        chk({tag, "_words"},   32'(bus.loaded_words), 32'(lw));
    endtask

    task automatic check_drained(input string tag);
        idle(2);
        chk({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset values
        chk("rst_in_ready",   32'(bus.in_ready),   32'd1);
        chk("rst_imem_we",    32'(bus.imem_we),    32'd0);
        chk("rst_imem_addr",  32'(bus.imem_addr),  32'd0);
        chk("rst_imem_wdata", bus.imem_wdata,      32'd0);
        check_status("rst", 1'b0, 1'b0, 1'b1, 0);

        // 1: good load
        push_good();
        send_good(1'b0, 1'b0);
        check_status("t1", 1'b1, 1'b0, 1'b0, 2);
        check_drained("t1");

        // 2: bad checksum, then recovery straight from ERR
        do_reset();
        push_good();
        send_good(1'b0, 1'b1);
        check_status("t2bad", 1'b0, 1'b1, 1'b1, 2);
        check_drained("t2bad");
        push_good();
        send_good(1'b0, 1'b0);
        check_status("t2good", 1'b1, 1'b0, 1'b0, 2);
        check_drained("t2good");

        // 3: leading garbage is dropped
        do_reset();
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h5A, 1'b0);
        push_good();
        send_good(1'b0, 1'b0);
        check_status("t3", 1'b1, 1'b0, 1'b0, 2);
        check_drained("t3");

        // 4: gaps in in_valid between every byte
        do_reset();
        push_good();
        send_good(1'b1, 1'b0);
        check_status("t4", 1'b1, 1'b0, 1'b0, 2);
        check_drained("t4");

        // 5: length over capacity (17 > 16), then zero-length frame
        do_reset();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h00, 1'b0);
        check_status("t5big", 1'b0, 1'b1, 1'b1, 0);
        chk("t5big_in_ready", 32'(bus.in_ready), 32'd1);
        check_drained("t5big");
        send_byte(8'hA5, 1'b0);
        chk("t5_error_cleared", 32'(bus.error), 32'd0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        check_status("t5zero", 1'b1, 1'b0, 1'b0, 0);
        check_drained("t5zero");

        // 6: reset in the middle of the first payload word
        do_reset();
        for (int i = 0; i < 6; i++) send_byte(good_frame[i], 1'b0);
        do_reset();
        chk("t6_addr", 32'(bus.imem_addr), 32'd0);
        chk("t6_in_ready", 32'(bus.in_ready), 32'd1);
        check_status("t6rst", 1'b0, 1'b0, 1'b1, 0);
        check_drained("t6rst");
        push_good();
        send_good(1'b0, 1'b0);
        check_status("t6", 1'b1, 1'b0, 1'b0, 2);
        check_drained("t6");

        // 7: DONE ignores further traffic
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        #1;
        chk("t7_in_ready", 32'(bus.in_ready), 32'd0);
        idle(5);
        bus.in_valid = 1'b0;
        chk("t7_addr", 32'(bus.imem_addr), 32'd1);
        chk("t7_wdata", bus.imem_wdata, 32'h0020_0093);
        check_status("t7", 1'b1, 1'b0, 1'b0, 2);
        check_drained("t7");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
